// File: rtl/memctrl_pkg.sv
// Shared codes, state encoding and helpers for the byte-serial memory controller.
package memctrl_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic              sgn;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      SIZE_W:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                               input logic [1:0] size, input logic sgn);
    case (size)
      SIZE_B:  return sgn ? {{24{d[7]}}, d[7:0]} : {24'd0, d[7:0]};
      SIZE_H:  return sgn ? {{16{d[15]}}, d[15:0]} : {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// One-hot request arbiter: fixed (highest index wins) or round-robin after the last grant.
module mem_rr_arbiter
  import memctrl_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] valid,
  input  logic              accept,
  output logic [NUM_CH-1:0] grant
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0] last_q;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (PRIO_MODE == 0) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (valid[c]) begin
          grant    = '0;
          grant[c] = 1'b1;
        end
      end
    end else begin
      // Search starts one past the last winner and wraps back onto it.
      for (int i = 1; i <= int'(NUM_CH); i++) begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
          if (!found && valid[c] && (c == (int'(last_q) + i) % int'(NUM_CH))) begin
            grant[c] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= '0;
    end else if (accept) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (grant[c]) last_q <= PTR_W'(c);
      end
    end
  end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Multi-channel byte-serial RAM controller: arbitrates, serialises loads/stores, extends loads.
module mem_arb_ctrl
  import memctrl_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [2*NUM_CH-1:0]      req_size,
  input  logic [NUM_CH-1:0]        req_signed,
  input  logic [ADDR_W*NUM_CH-1:0] req_addr,
  input  logic [32*NUM_CH-1:0]     req_wdata,
  input  logic [NUM_CH-1:0]        req_abort,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [31:0]              rsp_data,
  output logic                     busy,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr
);

  state_t              state_q;
  mem_req_t            req_q, sel_req;
  logic [NUM_CH-1:0]   own_q, grant, eligible;
  logic [ADDR_W-1:0]   addr_q, sel_addr;
  logic [2:0]          cnt_q, n_c;
  logic [1:0]          rcv_q;
  logic [DATA_W-1:0]   asm_q, asm_c;
  logic [RD_LAT-1:0]   tap_q, tap_next;
  logic                abt_q, issue_c, cap_c, last_c, abort_c, accept_c;

  // A reserved-size request answers next cycle from IDLE; keep the same channel
  // from winning again while its response is up so rsp_valid never repeats.
  always_comb begin
    eligible = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      eligible[c] = req_valid[c] & ~(rsp_valid[c] & (req_size[2*c +: 2] == SIZE_RSV));
    end
  end

  mem_rr_arbiter #(.NUM_CH(NUM_CH), .PRIO_MODE(PRIO_MODE)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (eligible),
    .accept (accept_c),
    .grant  (grant)
  );

  assign req_ready = ((state_q == IDLE) && rst) ? grant : '0;
  assign accept_c  = |req_ready;
  assign busy      = (state_q != IDLE);

  always_comb begin
    sel_req  = '0;
    sel_addr = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (grant[c]) begin
        sel_req.wr    = req_wr[c];
        sel_req.size  = req_size[2*c +: 2];
        sel_req.sgn   = req_signed[c];
        sel_req.wdata = req_wdata[32*c +: 32];
        sel_addr      = req_addr[ADDR_W*c +: ADDR_W];
      end
    end
  end

  // Tap line marks cycles whose load address returns a byte RD_LAT cycles later.
  always_comb begin
    n_c      = size_bytes(req_q.size);
    issue_c  = (state_q == XFER) && !req_q.wr;
    tap_next = RD_LAT'({tap_q, issue_c});
    cap_c    = tap_q[RD_LAT-1];
    asm_c    = asm_q;
    asm_c[{rcv_q, 3'b000} +: 8] = mem_din;
    last_c   = (rcv_q == 2'(n_c - 3'd1));
    abort_c  = !req_q.wr && (state_q != IDLE) && (|(req_abort & own_q));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      own_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      rcv_q     <= '0;
      asm_q     <= '0;
      tap_q     <= '0;
      abt_q     <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      mem_a     <= '0;
      mem_dout  <= '0;
      mem_wr    <= 1'b0;
    end else begin
      rsp_valid <= '0;
      tap_q     <= tap_next;
      if (cap_c) begin
        asm_q <= asm_c;
        rcv_q <= rcv_q + 2'd1;
      end
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            own_q       <= grant;
            req_q       <= sel_req;
            req_q.wdata <= sel_req.wdata >> 8;
            asm_q       <= '0;
            rcv_q       <= '0;
            abt_q       <= 1'b0;
            if (sel_req.size == SIZE_RSV) begin
              rsp_valid <= grant;
              rsp_data  <= '0;
            end else begin
              state_q  <= XFER;
              mem_a    <= sel_addr;
              mem_wr   <= sel_req.wr;
              mem_dout <= sel_req.wdata[7:0];
              addr_q   <= sel_addr + ADDR_W'(1);
              cnt_q    <= 3'd1;
            end
          end
        end
        XFER: begin
          if (abort_c || cnt_q == n_c) begin
            mem_a    <= '0;
            mem_wr   <= 1'b0;
            mem_dout <= '0;
            if (abort_c) begin
              abt_q   <= 1'b1;
              state_q <= DRAIN;
            end else if (req_q.wr) begin
              state_q   <= IDLE;
              rsp_valid <= own_q;
              rsp_data  <= '0;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            mem_a       <= addr_q;
            mem_wr      <= req_q.wr;
            mem_dout    <= req_q.wdata[7:0];
            addr_q      <= addr_q + ADDR_W'(1);
            req_q.wdata <= req_q.wdata >> 8;
            cnt_q       <= cnt_q + 3'd1;
          end
        end
        DRAIN: begin
          // Aborted loads flush outstanding bytes, then leave without responding.
          if (abt_q || abort_c) begin
            abt_q <= 1'b1;
            if (tap_next == '0) state_q <= IDLE;
          end else if (cap_c && last_c) begin
            state_q   <= IDLE;
            rsp_valid <= own_q;
            rsp_data  <= extend(asm_c, req_q.size, req_q.sgn);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl: loads, stores, wrap, arbitration, abort and reset cases.
module tb_mem_arb_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_wr, req_signed, req_abort, rsp_valid;
  logic [3:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] rsp_data, mem_a;
  logic        busy, mem_wr;
  logic [7:0]  mem_din, mem_dout;

  logic [1:0]  rr_valid, rr_ready, rr_rsp_valid;
  logic [3:0]  rr_size;
  logic [31:0] rr_rsp_data, rr_mem_a;
  logic        rr_busy, rr_mem_wr;
  logic [7:0]  rr_mem_dout;

  logic [7:0]  ram [0:511];
  logic        pl_en;
  logic [8:0]  pl_addr;
  logic [7:0]  pl_data;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arb_ctrl #(.NUM_CH(2), .ADDR_W(32), .RD_LAT(1), .PRIO_MODE(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_abort(req_abort), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  mem_arb_ctrl #(.NUM_CH(2), .ADDR_W(32), .RD_LAT(1), .PRIO_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .req_valid(rr_valid), .req_ready(rr_ready), .req_wr(2'b00),
    .req_size(rr_size), .req_signed(2'b00), .req_addr(64'd0), .req_wdata(64'd0),
    .req_abort(2'b00), .rsp_valid(rr_rsp_valid), .rsp_data(rr_rsp_data), .busy(rr_busy),
    .mem_din(8'h00), .mem_dout(rr_mem_dout), .mem_a(rr_mem_a), .mem_wr(rr_mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with one cycle of read latency plus a preload port.
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_wr) ram[mem_a[8:0]] <= mem_dout;
    mem_din <= ram[mem_a[8:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [8:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Presents one request from a negedge and returns at its accept edge.
  task automatic send(input int ch, input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd);
    req_valid = 2'b00;
    req_valid[ch] = 1'b1;
    req_wr[ch] = wr;
    req_size[2*ch +: 2] = sz;
    req_signed[ch] = sg;
    req_addr[32*ch +: 32] = a;
    req_wdata[32*ch +: 32] = wd;
    #1;
    check("ready", 32'(req_ready), 32'd1 << ch);
    @(posedge clk);
  endtask

  // Observes cycles T+1..T+maxc; k is the cycle index after the accept edge T.
  task automatic watch(input int maxc, input int abort_at, input logic [1:0] abort_mask,
                       output int rcyc, output logic [1:0] rbits, output logic [31:0] rdat,
                       output int wfirst, output int wcnt, output logic [31:0] wa,
                       output logic [15:0] bh);
    rcyc = 0; rbits = 2'b00; rdat = 32'd0; wfirst = 0; wcnt = 0; wa = 32'd0; bh = 16'd0;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      req_valid = 2'b00;
      req_abort = (k == abort_at) ? abort_mask : 2'b00;
      if (k < 16) bh[k] = busy;
      if (rsp_valid != 2'b00 && rcyc == 0) begin
        rcyc = k; rbits = rsp_valid; rdat = rsp_data;
      end
      if (mem_wr) begin
        if (wcnt == 0) begin wfirst = k; wa = mem_a; end
        wcnt++;
      end
    end
    req_abort = 2'b00;
  endtask

  int          rc, wf, wc;
  logic [1:0]  rb;
  logic [31:0] rd, wa;
  logic [15:0] bh;

  initial begin
    rst = 1'b0; req_valid = '0; req_wr = '0; req_size = '0; req_signed = '0;
    req_addr = '0; req_wdata = '0; req_abort = '0; rr_valid = '0; rr_size = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    req_valid = 2'b11;
    #1;
    check("rst_ready_gated", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    poke(9'h100, 8'h11); poke(9'h101, 8'h22); poke(9'h102, 8'h33); poke(9'h103, 8'h44);
    poke(9'h007, 8'h80); poke(9'h1FF, 8'h34); poke(9'h000, 8'h92);
    poke(9'h060, 8'hA0); poke(9'h061, 8'hA1); poke(9'h062, 8'hA2); poke(9'h063, 8'hA3);

    send(1, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    watch(10, 0, 2'b00, rc, rb, rd, wf, wc, wa, bh);
    check("lw_cycle", 32'(rc), 32'd6);
    check("lw_owner", 32'(rb), 32'h2);
    check("lw_data", rd, 32'h44332211);
    check("lw_busy_t5", 32'(bh[5]), 32'd1);
    check("lw_idle_t6", 32'(bh[6]), 32'd0);

    send(1, 1'b0, 2'b00, 1'b1, 32'h7, 32'd0);
    watch(10, 0, 2'b00, rc, rb, rd, wf, wc, wa, bh);
    check("lb_cycle", 32'(rc), 32'd3);
    check("lb_data", rd, 32'hFFFFFF80);

    send(0, 1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'd0);
    watch(10, 0, 2'b00, rc, rb, rd, wf, wc, wa, bh);
    check("lhu_cycle", 32'(rc), 32'd4);
    check("lhu_owner", 32'(rb), 32'h1);
    check("lhu_wrap_data", rd, 32'h00009234);

    send(1, 1'b0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'd0);
    watch(10, 0, 2'b00, rc, rb, rd, wf, wc, wa, bh);
    check("lh_data", rd, 32'hFFFF9234);

    send(0, 1'b0, 2'b11, 1'b0, 32'h100, 32'd0);
    watch(5, 0, 2'b00, rc, rb, rd, wf, wc, wa, bh);
    check("rsv_cycle", 32'(rc), 32'd1);
    check("rsv_data", rd, 32'd0);
    check("rsv_no_ram", 32'(wc), 32'd0);

    send(0, 1'b1, 2'b01, 1'b0, 32'h20, 32'h0000ABCD);
    watch(8, 0, 2'b00, rc, rb, rd, wf, wc, wa, bh);
    check("sh_wr_first", 32'(wf), 32'd1);
    check("sh_wr_count", 32'(wc), 32'd2);
    check("sh_wr_addr", wa, 32'h20);
    check("sh_rsp_cycle", 32'(rc), 32'd3);
    check("sh_rsp_owner", 32'(rb), 32'h1);
    check("sh_rsp_data", rd, 32'd0);
    check("sh_ram", {16'd0, ram[9'h021], ram[9'h020]}, 32'h0000ABCD);

    req_valid = 2'b11; req_size = 4'b1111;
    #1;
    check("fixed_prio", 32'(req_ready), 32'h2);
    @(posedge clk);
    watch(3, 0, 2'b00, rc, rb, rd, wf, wc, wa, bh);
    check("fixed_rsp_owner", 32'(rb), 32'h2);

    send(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    watch(10, 2, 2'b01, rc, rb, rd, wf, wc, wa, bh);
    check("abort_no_rsp", 32'(rc), 32'd0);
    check("abort_busy_t3", 32'(bh[3]), 32'd1);
    check("abort_idle_t4", 32'(bh[4]), 32'd0);

    send(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
    watch(10, 2, 2'b10, rc, rb, rd, wf, wc, wa, bh);
    check("sw_abort_ignored_cycle", 32'(rc), 32'd5);
    check("sw_abort_wr_count", 32'(wc), 32'd4);
    check("sw_abort_ram", {ram[9'h043], ram[9'h042], ram[9'h041], ram[9'h040]}, 32'hDEADBEEF);

    send(0, 1'b1, 2'b10, 1'b0, 32'h60, 32'h55667788);
    repeat (3) begin
      @(negedge clk);
      req_valid = 2'b00;
    end
    rst = 1'b0;
    #1;
    check("midrst_mem_wr", 32'(mem_wr), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_mem_a", mem_a, 32'd0);
    check("midrst_mem_dout", 32'(mem_dout), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(0, 1'b0, 2'b10, 1'b0, 32'h60, 32'd0);
    watch(10, 0, 2'b00, rc, rb, rd, wf, wc, wa, bh);
    check("midrst_lw_cycle", 32'(rc), 32'd6);
    check("midrst_lw_data", rd, 32'hA3A27788);

    rr_valid = 2'b11; rr_size = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_grant%0d", i), 32'(rr_ready), (i % 2 == 0) ? 32'h2 : 32'h1);
      @(negedge clk);
    end
    rr_valid = 2'b00;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
